// File: rtl/stream_join_buf_pkg.sv
// ---------------------------------------------------------------------------
// stream_join_buf_pkg
// Purpose : shared helpers for the buffered N-way stream join.
// Contents: ptr_w() - pointer width for a DEPTH-entry ring. It never returns
//           less than 1, so a single-entry lane still has a legal pointer
//           register.
// ---------------------------------------------------------------------------
package stream_join_buf_pkg;

    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/stream_join_lane.sv
// ---------------------------------------------------------------------------
// stream_join_lane
// Purpose : one DEPTH-entry FIFO lane of the stream join. There is no
//           fall-through: data written in cycle t is visible at data_o in
//           t+1. Pointers wrap DEPTH-1 -> 0, so DEPTH need not be a power
//           of two.
// Ports   : clk_i   - clock
//           clr_i   - synchronous flush of pointers and count (reset or clear)
//           push_i  - write data_i at the write pointer (caller guarantees !full)
//           pop_i   - advance the read pointer (caller guarantees !empty)
//           data_i  - write data
//           data_o  - head entry
//           count_o - occupancy 0..DEPTH
//           full_o  - count == DEPTH
//           empty_o - count == 0
// ---------------------------------------------------------------------------
module stream_join_lane
    import stream_join_buf_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 2
) (
    input  logic                         clk_i,
    input  logic                         clr_i,
    input  logic                         push_i,
    input  logic                         pop_i,
    input  logic [DATA_WIDTH-1:0]        data_i,
    output logic [DATA_WIDTH-1:0]        data_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o,
    output logic                         full_o,
    output logic                         empty_o
);

    localparam int PtrW = ptr_w(DEPTH);
    localparam int CntW = $clog2(DEPTH + 1);
    localparam logic [PtrW-1:0] LastPtr = PtrW'(DEPTH - 1);
    localparam logic [CntW-1:0] FullCnt = CntW'(DEPTH);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [PtrW-1:0]       r_rptr;
    logic [PtrW-1:0]       r_wptr;
    logic [CntW-1:0]       r_count;

    function automatic logic [PtrW-1:0] f_next_ptr(input logic [PtrW-1:0] p);
        return (p == LastPtr) ? '0 : p + PtrW'(1);
    endfunction

    // Control state: only pointers and count are reset.
    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            r_rptr  <= '0;
            r_wptr  <= '0;
            r_count <= '0;
        end else begin
            if (push_i) r_wptr <= f_next_ptr(r_wptr);
            if (pop_i)  r_rptr <= f_next_ptr(r_rptr);
            if (push_i && !pop_i)
                r_count <= r_count + CntW'(1);
            else if (!push_i && pop_i)
                r_count <= r_count - CntW'(1);
        end
    end

    // Storage is never reset; the count decides what is meaningful. A push
    // only targets a non-head slot unless the lane is empty, so the head
    // stays stable while the joined output is stalled.
    always_ff @(posedge clk_i) begin
        if (push_i) r_mem[r_wptr] <= data_i;
    end

    assign data_o  = r_mem[r_rptr];
    assign count_o = r_count;
    assign full_o  = (r_count == FullCnt);
    assign empty_o = (r_count == '0);

endmodule

// File: rtl/stream_join_buf.sv
// ---------------------------------------------------------------------------
// stream_join_buf
// Purpose : buffered N-way stream join. Each input stream feeds its own
//           DEPTH-entry lane; one joined beat (all lane heads concatenated)
//           is emitted only when every lane holds data. Early branches can
//           run ahead by up to DEPTH beats without stalling.
// Ports   : clk_i    - clock, all state on rising edge
//           rst_i    - synchronous active-high reset
//           clr_i    - synchronous clear, flushes all lanes
//           valid_i  - per-lane input valid       [N_INP]
//           ready_o  - per-lane input ready       [N_INP]
//           data_i   - lane i at [i*DATA_WIDTH +: DATA_WIDTH]
//           valid_o  - joined output valid
//           ready_i  - joined output ready
//           data_o   - lane heads, same packing as data_i
//           fill_o   - per-lane count, lane i at [i*CntW +: CntW]
// ---------------------------------------------------------------------------
module stream_join_buf
    import stream_join_buf_pkg::*;
#(
    parameter int N_INP      = 2,
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 2
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic                                clr_i,
    input  logic [N_INP-1:0]                    valid_i,
    output logic [N_INP-1:0]                    ready_o,
    input  logic [N_INP*DATA_WIDTH-1:0]         data_i,
    output logic                                valid_o,
    input  logic                                ready_i,
    output logic [N_INP*DATA_WIDTH-1:0]         data_o,
    output logic [N_INP*$clog2(DEPTH+1)-1:0]    fill_o
);

    localparam int CntW = $clog2(DEPTH + 1);

    logic             w_flush;
    logic [N_INP-1:0] w_full;
    logic [N_INP-1:0] w_empty;
    logic [N_INP-1:0] w_push;
    logic             w_pop;

    assign w_flush = rst_i || clr_i;

    // ready_o depends only on registered fullness, never on ready_i, so a
    // full lane stays not-ready even in the cycle it is popped.
    assign ready_o = ~w_full & {N_INP{~w_flush}};
    assign valid_o = ~(|w_empty) && !w_flush;
    assign w_push  = valid_i & ready_o;
    // One pop is broadcast to every lane; lanes never pop individually.
    assign w_pop   = valid_o && ready_i;

    for (genvar g = 0; g < N_INP; g++) begin : g_lane
        stream_join_lane #(
            .DATA_WIDTH (DATA_WIDTH),
            .DEPTH      (DEPTH)
        ) u_lane (
            .clk_i   (clk_i),
            .clr_i   (w_flush),
            .push_i  (w_push[g]),
            .pop_i   (w_pop),
            .data_i  (data_i[g*DATA_WIDTH +: DATA_WIDTH]),
            .data_o  (data_o[g*DATA_WIDTH +: DATA_WIDTH]),
            .count_o (fill_o[g*CntW +: CntW]),
            .full_o  (w_full[g]),
            .empty_o (w_empty[g])
        );

        // Source protocol: an offered beat stays offered, unchanged, until
        // taken. Cycles where reset or clear force ready low are exempt.
        a_valid_hold : assert property (@(posedge clk_i) disable iff (rst_i)
            (valid_i[g] && !ready_o[g] && !clr_i && !rst_i) |=> valid_i[g])
            else $error("stream_join_buf: valid_i[%0d] dropped without handshake", g);

        a_data_hold : assert property (@(posedge clk_i) disable iff (rst_i)
            (valid_i[g] && !ready_o[g] && !clr_i && !rst_i)
            |=> $stable(data_i[g*DATA_WIDTH +: DATA_WIDTH]))
            else $error("stream_join_buf: data_i lane %0d changed while stalled", g);
    end

    if (N_INP < 1) begin : g_bad_n_inp
        $error("stream_join_buf: N_INP must be >= 1");
    end
    if (DEPTH < 1) begin : g_bad_depth
        $error("stream_join_buf: DEPTH must be >= 1");
    end
    if (DATA_WIDTH < 1) begin : g_bad_width
        $error("stream_join_buf: DATA_WIDTH must be >= 1");
    end

endmodule
